// File: rtl/vend_pkg.sv
// Shared vending definitions: drink codes, prices, actuator state encoding.
// Pure declarations; no timing or flow control of its own.
package vend_pkg;

    localparam logic [1:0] DRINK_NONE   = 2'b00;
    localparam logic [1:0] DRINK_WATER  = 2'b01;
    localparam logic [1:0] DRINK_COKE   = 2'b10;
    localparam logic [1:0] DRINK_COFFEE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DISPENSE,
        EJECT_ON,
        EJECT_GAP,
        DONE
    } vend_state_e;

    // Coin price of each drink; NONE costs nothing.
    function automatic logic [2:0] drink_price(input logic [1:0] drink);
        logic [2:0] price;
        price = 3'd0;
        case (drink)
            DRINK_WATER:  price = 3'd1;
            DRINK_COKE:   price = 3'd2;
            DRINK_COFFEE: price = 3'd3;
            default:      price = 3'd0;
        endcase
        return price;
    endfunction

endpackage

// File: rtl/vend_actuator_if.sv
// Command/mechanism signal bundle between vending FSM, actuator and pins.
// slave = actuator view; master = the side driving commands and motor ack.
interface vend_actuator_if;

    logic [1:0] drink_cmd;
    logic [1:0] refund_cmd;
    logic       motor_done;
    logic       dispense_req;
    logic [1:0] dispense_sel;
    logic       coin_eject;
    logic [2:0] eject_remaining;
    logic       busy;
    logic       vend_done;
    logic       fault;
    logic       overrun;

    modport slave (
        input  drink_cmd, refund_cmd, motor_done,
        output dispense_req, dispense_sel, coin_eject, eject_remaining,
               busy, vend_done, fault, overrun
    );

    modport master (
        output drink_cmd, refund_cmd, motor_done,
        input  dispense_req, dispense_sel, coin_eject, eject_remaining,
               busy, vend_done, fault, overrun
    );

endinterface

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// An interval of N cycles is timed by loading N-1 on entry; no backpressure.
module vend_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/vend_actuator.sv
// Executes one drink/refund command: motor handshake, then timed coin pulses, then a done pulse.
// Commands arriving while busy are dropped (overrun). VEND_FAULT_REFUND_EN: refund the price on motor timeout.
module vend_actuator
    import vend_pkg::*;
#(
    parameter int EJECT_ON_CYCLES  = 4,
    parameter int EJECT_GAP_CYCLES = 4,
    parameter int MOTOR_TIMEOUT    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    vend_actuator_if.slave bus
);

    localparam int MAX_ON_GAP = (EJECT_ON_CYCLES > EJECT_GAP_CYCLES) ? EJECT_ON_CYCLES
                                                                     : EJECT_GAP_CYCLES;
    localparam int MAX_CYC    = (MOTOR_TIMEOUT > MAX_ON_GAP) ? MOTOR_TIMEOUT : MAX_ON_GAP;
    localparam int TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] MOTOR_LOAD = TW'(MOTOR_TIMEOUT - 1);
    localparam logic [TW-1:0] ON_LOAD    = TW'(EJECT_ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(EJECT_GAP_CYCLES - 1);

    vend_state_e state, state_nxt;
    logic [1:0]  drink_q, drink_nxt;
    logic [2:0]  refund_q, refund_nxt;
    logic        fault_q, fault_nxt;
    logic        overrun_q, overrun_nxt;

    logic          cmd_vld;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_tc;

    assign cmd_vld = (bus.drink_cmd != DRINK_NONE) || (bus.refund_cmd != 2'd0);

    vend_pulse_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drink_q   <= DRINK_NONE;
            refund_q  <= 3'd0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            drink_q   <= drink_nxt;
            refund_q  <= refund_nxt;
            fault_q   <= fault_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        drink_nxt   = drink_q;
        refund_nxt  = refund_q;
        fault_nxt   = fault_q;
        overrun_nxt = overrun_q | (cmd_vld && (state != IDLE));
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    drink_nxt  = bus.drink_cmd;
                    refund_nxt = {1'b0, bus.refund_cmd};
                    state_nxt  = (bus.drink_cmd != DRINK_NONE) ? DISPENSE : EJECT_ON;
                end
            end
            DISPENSE: begin
                // A motor ack on the timeout cycle still counts as success.
                if (bus.motor_done) begin
                    state_nxt = (refund_q != 3'd0) ? EJECT_ON : DONE;
                end else if (tmr_tc) begin
                    fault_nxt = 1'b1;
`ifdef VEND_FAULT_REFUND_EN
                    refund_nxt = refund_q + drink_price(drink_q);
`else
                    refund_nxt = refund_q;
`endif
                    state_nxt = (refund_nxt != 3'd0) ? EJECT_ON : DONE;
                end
            end
            EJECT_ON: begin
                if (tmr_tc) begin
                    refund_nxt = refund_q - 3'd1;
                    state_nxt  = EJECT_GAP;
                end
            end
            EJECT_GAP: begin
                if (tmr_tc) begin
                    state_nxt = (refund_q != 3'd0) ? EJECT_ON : DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Every timed state is entered from a different state, so a state change marks a new interval.
        if (state_nxt != state) begin
            case (state_nxt)
                DISPENSE:  begin tmr_load = 1'b1; tmr_val = MOTOR_LOAD; end
                EJECT_ON:  begin tmr_load = 1'b1; tmr_val = ON_LOAD;    end
                EJECT_GAP: begin tmr_load = 1'b1; tmr_val = GAP_LOAD;   end
                default:   begin tmr_load = 1'b0; tmr_val = '0;         end
            endcase
        end
    end

    // Pin drives decode the state register directly so reset drops them without a clock.
    assign bus.dispense_req    = (state == DISPENSE);
    assign bus.dispense_sel    = (state == DISPENSE) ? drink_q : DRINK_NONE;
    assign bus.coin_eject      = (state == EJECT_ON);
    assign bus.eject_remaining = refund_q;
    assign bus.busy            = (state != IDLE);
    assign bus.vend_done       = (state == DONE);
    assign bus.fault           = fault_q;
    assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_vend_actuator.sv
// Scoreboard bench for vend_actuator: each command pushes its expected outcome, the monitor pops it on vend_done.
`timescale 1ns/1ps
module tb_vend_actuator;

    localparam int ON  = 4;
    localparam int GAP = 4;
    localparam int MT  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vend_actuator_if bus();

    vend_actuator #(
        .EJECT_ON_CYCLES  (ON),
        .EJECT_GAP_CYCLES (GAP),
        .MOTOR_TIMEOUT    (MT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] drink;
        int         coins;
        int         disp;
        logic       fault;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_fault = 1'b0;

    // monitor accumulators for the transaction in flight
    int         disp_cnt, pulses, on_len, gap_len;
    logic       gap_active, prev_coin, timing_bad, sel_bad;
    logic [1:0] obs_sel, obs_drink;
    exp_t       e;

    function automatic int price(input logic [1:0] d);
        case (d)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    function void mon_clear();
        disp_cnt   = 0;
        pulses     = 0;
        on_len     = 0;
        gap_len    = 0;
        gap_active = 1'b0;
        timing_bad = 1'b0;
        sel_bad    = 1'b0;
        obs_sel    = 2'b00;
    endfunction

    initial mon_clear();

    always @(negedge clk) begin
        if (rst) begin
            mon_clear();
            prev_coin = 1'b0;
        end else begin
            if (bus.dispense_req) begin
                if (disp_cnt == 0) obs_sel = bus.dispense_sel;
                else if (bus.dispense_sel !== obs_sel) sel_bad = 1'b1;
                disp_cnt++;
            end
            if (bus.coin_eject) begin
                if (!prev_coin) begin
                    if (gap_active && gap_len != GAP) timing_bad = 1'b1;
                    gap_active = 1'b0;
                    on_len = 0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL eject_start: coin pulse with no pending command");
                    end else if (int'(bus.eject_remaining) != q[0].coins - pulses) begin
                        errors++;
                        $display("FAIL eject_remaining_on: got %0d expected %0d",
                                 bus.eject_remaining, q[0].coins - pulses);
                    end
                end
                on_len++;
            end else begin
                if (prev_coin) begin
                    pulses++;
                    if (on_len != ON) timing_bad = 1'b1;
                    gap_active = 1'b1;
                    gap_len = 0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL eject_end: coin pulse with no pending command");
                    end else if (int'(bus.eject_remaining) != q[0].coins - pulses) begin
                        errors++;
                        $display("FAIL eject_remaining_gap: got %0d expected %0d",
                                 bus.eject_remaining, q[0].coins - pulses);
                    end
                end
                if (gap_active) gap_len++;
            end
            if (bus.vend_done) begin
                // gap_len includes this DONE cycle on top of the final gap
                if (pulses > 0 && gap_len != GAP + 1) timing_bad = 1'b1;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL vend_done_unexpected: got pulse expected none");
                end else begin
                    e = q.pop_front();
                    obs_drink = (disp_cnt > 0) ? obs_sel : 2'b00;
                    if (obs_drink !== e.drink) begin
                        errors++;
                        $display("FAIL dispense_sel: got %b expected %b", obs_drink, e.drink);
                    end
                    checks++;
                    if (sel_bad !== 1'b0) begin
                        errors++;
                        $display("FAIL dispense_sel_stable: got unstable expected stable");
                    end
                    checks++;
                    if (disp_cnt != e.disp) begin
                        errors++;
                        $display("FAIL dispense_cycles: got %0d expected %0d", disp_cnt, e.disp);
                    end
                    checks++;
                    if (pulses != e.coins) begin
                        errors++;
                        $display("FAIL coin_pulses: got %0d expected %0d", pulses, e.coins);
                    end
                    checks++;
                    if (timing_bad !== 1'b0) begin
                        errors++;
                        $display("FAIL eject_timing: got bad on/gap length expected on %0d gap %0d", ON, GAP);
                    end
                    checks++;
                    if (bus.fault !== e.fault) begin
                        errors++;
                        $display("FAIL fault_at_done: got %b expected %b", bus.fault, e.fault);
                    end
                end
                mon_clear();
            end
            prev_coin = bus.coin_eject;
        end
    end

    task automatic push_exp(input logic [1:0] d, input int coins, input int disp, input logic f);
        exp_t x;
        x.drink = d;
        x.coins = coins;
        x.disp  = disp;
        x.fault = f;
        q.push_back(x);
    endtask

    task automatic issue(input logic [1:0] d, input logic [1:0] r);
        @(posedge clk); #1;
        bus.drink_cmd  = d;
        bus.refund_cmd = r;
        @(posedge clk); #1;
        bus.drink_cmd  = 2'b00;
        bus.refund_cmd = 2'b00;
    endtask

    task automatic wait_disp(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dispense_req && n < 20);
        checks++;
        if (!bus.dispense_req) begin
            errors++;
            $display("FAIL %s_dispense_req: got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic wait_coin(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.coin_eject && n < 40);
        checks++;
        if (!bus.coin_eject) begin
            errors++;
            $display("FAIL %s_coin_eject: got 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic pulse_motor_after(input int n);
        repeat (n) @(posedge clk);
        #1 bus.motor_done = 1'b1;
        @(posedge clk);
        #1 bus.motor_done = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_done_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.vend_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: got busy %b vend_done %b expected 0 0", name, bus.busy, bus.vend_done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.dispense_req, bus.dispense_sel, bus.coin_eject, bus.eject_remaining,
             bus.busy, bus.vend_done, bus.fault, bus.overrun} !== 11'b0) begin
            errors++;
            $display("FAIL %s: got req %b sel %b coin %b rem %0d busy %b done %b fault %b ovr %b expected all 0",
                     name, bus.dispense_req, bus.dispense_sel, bus.coin_eject, bus.eject_remaining,
                     bus.busy, bus.vend_done, bus.fault, bus.overrun);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_state");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_coke_dispense();
        push_exp(2'b10, 0, 5, exp_fault);
        issue(2'b10, 2'b00);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL coke_busy: got %b expected 1", bus.busy);
        end
        wait_disp("coke");
        pulse_motor_after(4);
        wait_done("coke", 50);
    endtask

    task automatic test_refund_only();
        push_exp(2'b00, 2, 0, exp_fault);
        issue(2'b00, 2'b10);
        wait_done("refund", 100);
    endtask

    task automatic test_motor_coincident();
        push_exp(2'b11, 1, MT, exp_fault);
        issue(2'b11, 2'b01);
        wait_disp("coincident");
        pulse_motor_after(MT - 1);
        wait_done("coincident", 100);
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL coincident_fault: got %b expected 0", bus.fault);
        end
    endtask

    task automatic test_motor_timeout();
        int coins;
`ifdef VEND_FAULT_REFUND_EN
        coins = 1 + price(2'b01);
`else
        coins = 1;
`endif
        exp_fault = 1'b1;
        push_exp(2'b01, coins, MT, 1'b1);
        issue(2'b01, 2'b01);
        wait_done("timeout", 200);
        checks++;
        if (bus.fault !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fault_sticky: got %b expected 1", bus.fault);
        end
    endtask

    task automatic test_overrun();
        logic stray_busy = 1'b0;
        push_exp(2'b00, 2, 0, exp_fault);
        issue(2'b00, 2'b10);
        wait_coin("overrun");
        @(posedge clk); #1;
        bus.drink_cmd  = 2'b11;
        bus.refund_cmd = 2'b01;
        @(posedge clk); #1;
        bus.drink_cmd  = 2'b00;
        bus.refund_cmd = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b expected 1", bus.overrun);
        end
        wait_done("overrun", 100);
        repeat (25) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) stray_busy = 1'b1;
        end
        checks++;
        if (stray_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_dropped_cmd: got busy after drop expected idle");
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 1", bus.overrun);
        end
    endtask

    task automatic test_rst_mid_op();
        // abort during DISPENSE; fault and overrun are both set from earlier tests
        push_exp(2'b01, 2, 0, 1'b0);
        issue(2'b01, 2'b10);
        wait_disp("rst_disp");
        #1 rst = 1'b1;
        #1 check_idle_outputs("rst_mid_dispense");
        q.delete();
        exp_fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        push_exp(2'b00, 3, 0, 1'b0);
        issue(2'b00, 2'b11);
        wait_coin("rst_eject");
        #1 rst = 1'b1;
        #1 check_idle_outputs("rst_mid_eject");
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        check_idle_outputs("rst_no_done");

        push_exp(2'b01, 1, 3, 1'b0);
        issue(2'b01, 2'b01);
        wait_disp("rst_next");
        pulse_motor_after(2);
        wait_done("rst_next", 60);
        checks++;
        if (bus.fault !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_flags: got fault %b overrun %b expected 0 0", bus.fault, bus.overrun);
        end
    endtask

    initial begin
        bus.drink_cmd  = 2'b00;
        bus.refund_cmd = 2'b00;
        bus.motor_done = 1'b0;
        test_reset();
        test_coke_dispense();
        test_refund_only();
        test_motor_coincident();
        test_motor_timeout();
        test_overrun();
        test_rst_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
